// File: rtl/pc_sequencer.sv
// Instruction-fetch sequencer: owns the PC, issues single-outstanding fetches,
// holds one instruction for decode and applies JAL/JALR redirects from execute.
module pc_sequencer #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_addr,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  output logic        inst_valid,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  input  logic        inst_ready,
  input  logic        redir_valid,
  input  logic [6:0]  redir_opcode,
  input  logic [31:0] redir_jump,
  input  logic [31:0] redir_ra,
  output logic        misalign_err
);

  localparam logic [6:0] OP_JAL  = 7'b1101111;
  localparam logic [6:0] OP_JALR = 7'b1100111;

  typedef enum logic [1:0] {IDLE, REQ, WAIT, HOLD} state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        drop_q, drop_d;
  logic        req_valid_q, req_valid_d;
  logic [31:0] addr_q, addr_d;
  logic        inst_valid_q, inst_valid_d;
  logic [31:0] inst_q, inst_d;
  logic [31:0] inst_pc_q, inst_pc_d;
  logic        misalign_q, misalign_d;

  logic        taken;
  logic [31:0] target;

  always_comb begin
    taken  = redir_valid && (redir_opcode == OP_JAL || redir_opcode == OP_JALR);
    target = (redir_opcode == OP_JAL) ? redir_jump : (redir_ra & ~32'h1);

    state_d   = state_q;
    pc_d      = pc_q;
    drop_d    = drop_q;
    inst_d    = inst_q;
    inst_pc_d = inst_pc_q;

    case (state_q)
      IDLE: begin
        state_d = REQ;
        if (taken) pc_d = target;
      end
      REQ: begin
        if (imem_req_ready) state_d = WAIT;
        // The request stays on the bus at its old address; its response is dropped later.
        if (taken) begin
          pc_d   = target;
          drop_d = 1'b1;
        end
      end
      WAIT: begin
        if (imem_resp_valid) begin
          if (drop_q || taken) begin
            drop_d  = 1'b0;
            state_d = REQ;
            if (taken) pc_d = target;
          end else begin
            inst_d    = imem_resp_data;
            inst_pc_d = pc_q;
            state_d   = HOLD;
          end
        end else if (taken) begin
          drop_d = 1'b1;
          pc_d   = target;
        end
      end
      HOLD: begin
        if (taken) begin
          pc_d    = target;
          state_d = REQ;
        end else if (inst_ready) begin
          pc_d    = pc_q + 32'd4;
          state_d = REQ;
        end
      end
      default: state_d = IDLE;
    endcase

    // Outputs are registered copies of the next-state decode.
    req_valid_d  = (state_d == REQ);
    inst_valid_d = (state_d == HOLD);
    addr_d       = (state_d == REQ && state_q != REQ) ? pc_d : addr_q;
    misalign_d   = taken && (target[1:0] != 2'b00);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      pc_q         <= RESET_PC;
      drop_q       <= 1'b0;
      req_valid_q  <= 1'b0;
      addr_q       <= RESET_PC;
      inst_valid_q <= 1'b0;
      inst_q       <= '0;
      inst_pc_q    <= '0;
      misalign_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      drop_q       <= drop_d;
      req_valid_q  <= req_valid_d;
      addr_q       <= addr_d;
      inst_valid_q <= inst_valid_d;
      inst_q       <= inst_d;
      inst_pc_q    <= inst_pc_d;
      misalign_q   <= misalign_d;
    end
  end

  assign imem_req_valid = req_valid_q;
  assign imem_addr      = addr_q;
  assign inst_valid     = inst_valid_q;
  assign inst           = inst_q;
  assign inst_pc        = inst_pc_q;
  assign misalign_err   = misalign_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: reactive memory model, architectural next-PC model,
// directed scenarios followed by randomized traffic.
module tb_pc_sequencer;

  localparam logic [31:0] RST_PC  = 32'h0000_1000;
  localparam logic [6:0]  OP_JAL  = 7'b1101111;
  localparam logic [6:0]  OP_JALR = 7'b1100111;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req_valid, imem_req_ready, imem_resp_valid;
  logic [31:0] imem_addr, imem_resp_data;
  logic        inst_valid, inst_ready;
  logic [31:0] inst, inst_pc;
  logic        redir_valid;
  logic [6:0]  redir_opcode;
  logic [31:0] redir_jump, redir_ra;
  logic        misalign_err;

  always #5 clk = ~clk;

  pc_sequencer #(.RESET_PC(RST_PC)) dut (
    .clk(clk), .rst(rst),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_addr(imem_addr),
    .imem_resp_valid(imem_resp_valid), .imem_resp_data(imem_resp_data),
    .inst_valid(inst_valid), .inst(inst), .inst_pc(inst_pc), .inst_ready(inst_ready),
    .redir_valid(redir_valid), .redir_opcode(redir_opcode),
    .redir_jump(redir_jump), .redir_ra(redir_ra),
    .misalign_err(misalign_err)
  );

  int n_tests = 0, n_fail = 0, cyc = 0, stall = 0;
  int p_ready = 100, p_ir = 100, p_redir = 0, p_rst = 0, lat_min = 0, lat_max = 0;
  bit          f_rst = 1'b0, f_redir = 1'b0;
  logic [6:0]  f_op = '0;
  logic [31:0] f_jump = '0, f_ra = '0;

  logic [31:0] exp_pc = RST_PC, req_exp = RST_PC;
  bit exp_mis = 1'b0, prev_iv = 1'b0, prev_kill = 1'b0, prev_rv = 1'b0, prev_acc = 1'b0, prev_rst = 1'b0;
  bit          mem_busy = 1'b0;
  int          mem_cnt = 0;
  logic [31:0] mem_addr = '0;
  int          acc_cyc[$];
  logic [31:0] acc_addr[$];

  function automatic logic [31:0] memfn(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'hC0DE_F00D;
  endfunction

  task automatic chk(input string tag, input logic [95:0] act, input logic [95:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  task automatic tick();
    bit          taken, hs;
    logic [31:0] tgt;
    @(negedge clk);
    cyc++;
    // compare this cycle's outputs with the model
    chk("misalign", misalign_err, exp_mis);
    if (prev_iv && !prev_kill) chk("inst_valid_hold", inst_valid, 1);
    if (prev_iv && prev_kill)  chk("inst_valid_drop", inst_valid, 0);
    if (inst_valid) begin
      chk("inst_pc", inst_pc, exp_pc);
      chk("inst_data", inst, memfn(exp_pc));
    end
    if (prev_rv && !prev_acc && !prev_rst) chk("req_hold", imem_req_valid, 1);
    if (imem_req_valid) begin
      chk("one_outstanding", mem_busy, 0);
      if (!prev_rv || prev_rst) begin
        chk("req_addr", imem_addr, exp_pc);
        req_exp = exp_pc;
      end else begin
        chk("req_addr_stable", imem_addr, req_exp);
      end
    end
    if (inst_valid && !prev_iv) stall = 0;
    else stall++;
    if (stall > 300) begin
      chk("progress_timeout", 0, 1);
      stall = 0;
    end

    // drive this cycle's inputs
    rst = f_rst || ($urandom_range(0, 999) < p_rst);
    imem_req_ready = ($urandom_range(0, 99) < p_ready);
    if (mem_busy && mem_cnt == 0) begin
      imem_resp_valid = 1'b1;
      imem_resp_data  = memfn(mem_addr);
      mem_busy        = 1'b0;
    end else begin
      imem_resp_valid = 1'b0;
      imem_resp_data  = $urandom;
      if (mem_busy) mem_cnt--;
    end
    inst_ready = ($urandom_range(0, 99) < p_ir);
    if (f_redir) begin
      redir_valid = 1'b1; redir_opcode = f_op; redir_jump = f_jump; redir_ra = f_ra;
    end else begin
      redir_valid = ($urandom_range(0, 99) < p_redir);
      case ($urandom_range(0, 2))
        0:       redir_opcode = OP_JAL;
        1:       redir_opcode = OP_JALR;
        default: redir_opcode = 7'($urandom);
      endcase
      redir_jump = $urandom & ~32'h1;
      redir_ra   = $urandom;
    end
    f_rst = 1'b0;
    f_redir = 1'b0;

    if (rst) mem_busy = 1'b0;
    else if (imem_req_valid && imem_req_ready) begin
      mem_busy = 1'b1;
      mem_addr = imem_addr;
      mem_cnt  = $urandom_range(lat_min, lat_max);
      acc_cyc.push_back(cyc);
      acc_addr.push_back(imem_addr);
    end

    // architectural next-PC model
    taken = redir_valid && (redir_opcode == OP_JAL || redir_opcode == OP_JALR);
    tgt   = (redir_opcode == OP_JAL) ? redir_jump : {redir_ra[31:1], 1'b0};
    hs    = inst_valid && inst_ready;
    prev_kill = rst || taken || hs;
    prev_iv   = inst_valid;
    prev_rv   = imem_req_valid;
    prev_acc  = imem_req_valid && imem_req_ready;
    prev_rst  = rst;
    if (rst) begin
      exp_pc  = RST_PC;
      exp_mis = 1'b0;
    end else begin
      exp_mis = taken && (tgt[1:0] != 2'b00);
      if (taken)   exp_pc = tgt;
      else if (hs) exp_pc = exp_pc + 32'd4;
    end
  endtask

  task automatic wait_iv();
    bit seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      tick();
      seen = inst_valid;
    end
    if (!seen) chk("wait_inst_timeout", 0, 1);
  endtask

  task automatic wait_req();
    bit seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      tick();
      seen = imem_req_valid;
    end
    if (!seen) chk("wait_req_timeout", 0, 1);
  endtask

  task automatic wait_accept(input int n);
    for (int i = 0; i < 40 && acc_addr.size() <= n; i++) tick();
    if (acc_addr.size() <= n) chk("wait_accept_timeout", 0, 1);
  endtask

  initial begin
    int n;
    rst = 1'b1; imem_req_ready = 1'b0; imem_resp_valid = 1'b0; imem_resp_data = '0;
    inst_ready = 1'b0; redir_valid = 1'b0; redir_opcode = '0; redir_jump = '0; redir_ra = '0;

    // reset values, one IDLE cycle, then first request
    tick();
    chk("rst_req_valid", imem_req_valid, 0);
    chk("rst_addr", imem_addr, RST_PC);
    chk("rst_inst_valid", inst_valid, 0);
    chk("rst_inst", inst, 0);
    chk("rst_inst_pc", inst_pc, 0);
    chk("rst_misalign", misalign_err, 0);
    tick();
    chk("first_req_valid", imem_req_valid, 1);
    chk("first_req_addr", imem_addr, RST_PC);

    // zero-wait streaming: one fetch every 3 cycles
    repeat (7) tick();
    chk("stream_accepts", acc_addr.size() >= 3, 1);
    if (acc_addr.size() >= 3) begin
      chk("stream_addr0", acc_addr[0], 32'h1000);
      chk("stream_addr1", acc_addr[1], 32'h1004);
      chk("stream_addr2", acc_addr[2], 32'h1008);
      chk("stream_gap01", acc_cyc[1] - acc_cyc[0], 3);
      chk("stream_gap12", acc_cyc[2] - acc_cyc[1], 3);
    end

    // decode backpressure in HOLD
    p_ir = 0;
    wait_iv();
    repeat (5) begin
      tick();
      chk("no_req_in_hold", imem_req_valid, 0);
    end
    p_ir = 100;
    tick();
    tick();
    chk("req_after_accept", imem_req_valid, 1);

    // JAL while a fetch is outstanding
    lat_min = 2; lat_max = 2;
    wait_req();
    n = acc_addr.size();
    f_redir = 1'b1; f_op = OP_JAL; f_jump = 32'h0000_2000;
    tick();
    wait_accept(n);
    chk("jal_next_fetch", acc_addr[acc_addr.size()-1], 32'h2000);

    // JALR to an odd-halfword target while holding an instruction
    lat_min = 0; lat_max = 0; p_ir = 0;
    wait_iv();
    f_redir = 1'b1; f_op = OP_JALR; f_ra = 32'h0000_3003;
    tick();
    tick();
    chk("jalr_misalign", misalign_err, 1);
    chk("jalr_req_valid", imem_req_valid, 1);
    chk("jalr_req_addr", imem_addr, 32'h3002);
    tick();
    chk("misalign_pulse_end", misalign_err, 0);
    p_ir = 100;

    // non-control opcode is ignored
    f_redir = 1'b1; f_op = 7'b0010011; f_jump = 32'h5000; f_ra = 32'h6000;
    tick();
    repeat (10) tick();

    // wrap of the sequential PC
    f_redir = 1'b1; f_op = OP_JAL; f_jump = 32'hFFFF_FFFC;
    tick();
    repeat (12) tick();

    // reset while a dropped fetch is outstanding
    lat_min = 2; lat_max = 2;
    wait_req();
    f_redir = 1'b1; f_op = OP_JAL; f_jump = 32'h4000;
    tick();
    f_rst = 1'b1;
    tick();
    tick();
    chk("rst_wait_idle_req", imem_req_valid, 0);
    chk("rst_wait_inst_valid", inst_valid, 0);
    tick();
    chk("rst_wait_req", imem_req_valid, 1);
    chk("rst_wait_addr", imem_addr, RST_PC);
    repeat (10) tick();

    // randomized traffic
    p_ready = 70; lat_min = 0; lat_max = 3; p_ir = 60; p_redir = 8; p_rst = 3;
    repeat (4000) tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Instruction-fetch controller that owns the program counter and sequences the next-PC selection (PC+4, JAL target, JALR return address) against a single-outstanding-request instruction memory. It sits between the instruction memory port and decode. It holds one fetched instruction until decode accepts it, and it applies JAL/JALR redirects from execute, discarding any fetch that is still in flight when a redirect arrives.

## Interface
- RESET_PC, 32'h0000_0000, PC loaded on reset.
- clk  in  1  clock, all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- imem_req_valid  out  1  fetch request valid.
- imem_req_ready  in  1  memory accepts request this cycle.
- imem_addr  out  32  fetch address, held stable while imem_req_valid is high and not accepted.
- imem_resp_valid  in  1  response data valid (one per accepted request).
- imem_resp_data  in  32  fetched instruction word.
- inst_valid  out  1  instruction available to decode.
- inst  out  32  instruction word.
- inst_pc  out  32  PC of inst.
- inst_ready  in  1  decode accepts inst this cycle.
- redir_valid  in  1  execute presents a control-flow instruction.
- redir_opcode  in  7  opcode of that instruction.
- redir_jump  in  32  JAL target.
- redir_ra  in  32  JALR computed target.
- misalign_err  out  1  one-cycle pulse: redirect target bits [1:0] nonzero after masking.

## Operation
- Next-PC selection:
  - redir_valid with opcode 7'b1101111 (JAL) → redir_jump.
  - redir_valid with opcode 7'b1100111 (JALR) → {redir_ra[31:1],1'b0}.
  - Any other opcode, or redir_valid low → pc+4 (32-bit wrap, 32'hFFFF_FFFC+4 = 0).
- A "taken redirect" is redir_valid with the JAL or JALR opcode. If the final target has bit 1 set, misalign_err pulses the next cycle. The redirect is still applied and the target is fetched unmodified.
- FSM states: IDLE, REQ, WAIT, HOLD.
  - IDLE: entered on reset; lasts exactly one cycle, then REQ. Responses arriving in IDLE are ignored.
  - REQ: imem_req_valid=1, imem_addr=pc. On imem_req_ready, go to WAIT.
  - WAIT: single outstanding request. On imem_resp_valid:
    - drop flag clear: latch inst=imem_resp_data, inst_pc=pc, and go to HOLD.
    - drop flag set: discard the data, clear drop, and go to REQ at the redirected pc.
  - HOLD: inst_valid=1. On inst_ready, pc←pc+4 and go to REQ.
- Redirect handling:
  - REQ: the request is not withdrawn. It completes at the old address, with drop set and pc←target.
  - WAIT: drop set, pc←target.
  - HOLD: inst_valid deasserts next cycle, pc←target, go to REQ.
- Simultaneous events:
  - Redirect and inst_ready in HOLD: the handshake completes and the target wins over pc+4.
  - Redirect and imem_resp_valid in WAIT: the response is discarded.
  - Redirect and imem_req_ready in REQ: the request is accepted and drop is set.
  - Back-to-back redirects: the last one wins; drop stays set.
- Reset mid-operation: the FSM goes to IDLE, pc←RESET_PC, drop clears, and inst_valid clears. The memory is reset by the same rst, so no stale response is expected.

## Timing
- Reset values: imem_req_valid=0, imem_addr=RESET_PC, inst_valid=0, inst=0, inst_pc=0, misalign_err=0, state=IDLE.
- First request: imem_req_valid rises on the second cycle after the rst-high edge (one IDLE cycle).
- Zero-wait memory (ready=1, response one cycle after acceptance):
  - REQ at cycle n, response at n+1, inst_valid at n+2.
  - If inst_ready=1, the next REQ is at n+3. Throughput is one instruction per 3 cycles.
- Redirect in HOLD at cycle n: REQ to the target at n+1.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Test plan
- Reset with RESET_PC=32'h0000_1000, ready=1, resp one cycle later, inst_ready=1 → requests to 1000, 1004, 1008 at 3-cycle spacing; inst_pc matches each address.
- Hold inst_ready=0 for 5 cycles in HOLD → inst and inst_pc stable; no new imem_req_valid; the request resumes the cycle after acceptance.
- JAL redirect (jump=32'h0000_2000) in WAIT for fetch of 1004 → 1004 data never appears on inst; next request is to 2000.
- JALR with ra=32'h0000_3003 in HOLD → next request is to 3002; misalign_err pulses once.
- redir_valid with opcode 7'b0010011 → ignored; sequential fetch continues at pc+4.
- Assert rst during WAIT with a redirect pending → IDLE, then a request to RESET_PC; no discarded-response behaviour carries over.
